// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stream_pkg
//  Description : Shared stream types, defaults and the length-word decode
//                helpers used by ndata_packetizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

  localparam int unsigned LENGTH_WIDTH_DEFAULT = 32;

  // Working width of the decode helpers; one guard bit is added on top so a
  // length of all ones cannot wrap during the round-up add.
  localparam int unsigned DECODE_WIDTH = 64;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } packetizer_state_t;

  // Number of beats needed to carry len elements, n elements per beat.
  function automatic logic [DECODE_WIDTH-1:0] decode_beats(
    input logic [DECODE_WIDTH-1:0] len,
    input int unsigned             n
  );
    logic [DECODE_WIDTH:0] sum;
    sum = {1'b0, len} + (DECODE_WIDTH+1)'(n - 1);
    return DECODE_WIDTH'(sum / (DECODE_WIDTH+1)'(n));
  endfunction

  // Keep mask of the final beat: low (len mod n) lanes, or every lane when
  // the length is an exact multiple of the beat width.
  function automatic logic [DECODE_WIDTH-1:0] decode_tail_keep(
    input logic [DECODE_WIDTH-1:0] len,
    input int unsigned             n
  );
    logic [DECODE_WIDTH-1:0] rem;
    rem = len % DECODE_WIDTH'(n);
    if (rem == '0) begin
      return (DECODE_WIDTH'(1) << n) - DECODE_WIDTH'(1);
    end
    return (DECODE_WIDTH'(1) << rem) - DECODE_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ndata_i.sv
`default_nettype none
// ============================================================================
//  Interface   : ndata_i
//  Description : Multi-element data stream with per-lane keep and last.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ndata_i #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_ELEMENTS = 4
) ();
  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] data;
  logic [NUM_ELEMENTS-1:0]                 keep;
  logic                                    last;
  logic                                    valid;
  logic                                    ready;

  modport m (output data, output keep, output last, output valid, input ready);
  modport s (input data, input keep, input last, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/ready_valid_i.sv
`default_nettype none
// ============================================================================
//  Interface   : ready_valid_i
//  Description : Plain valid/ready word stream (used for the length words).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ready_valid_i #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport m (output data, output valid, input ready);
  modport s (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/NDataSkidBuffer.sv
`default_nettype none
// ============================================================================
//  Module      : NDataSkidBuffer
//  Description : Two-entry skid buffer for ndata_i streams. Full throughput,
//                upstream ready comes straight from a register.
//  Revision    : 1.0 - initial release
// ============================================================================
module NDataSkidBuffer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_ELEMENTS = 4
) (
  input  logic clk,
  input  logic rst_n,
  ndata_i.s    in,
  ndata_i.m    out
);

  typedef struct packed {
    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] data;
    logic [NUM_ELEMENTS-1:0]                 keep;
    logic                                    last;
  } beat_t;

  beat_t out_beat_q, out_beat_d, skid_beat_q, skid_beat_d;
  logic  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  beat_t w_in_beat;
  logic  w_in_hs;
  logic  w_out_advance;

  assign w_in_beat     = {in.data, in.keep, in.last};
  assign in.ready      = !skid_valid_q;
  assign w_in_hs       = in.valid && !skid_valid_q;
  assign w_out_advance = !out_valid_q || out.ready;

  assign out.valid = out_valid_q;
  assign out.data  = out_beat_q.data;
  assign out.keep  = out_beat_q.keep;
  assign out.last  = out_beat_q.last;

  // Refill the output register from the skid entry first, otherwise from the
  // input; park an incoming beat in the skid entry while the output stalls.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_beat_d   = out_beat_q;
    skid_valid_d = skid_valid_q;
    skid_beat_d  = skid_beat_q;
    if (w_out_advance) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_beat_d   = skid_beat_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = w_in_hs;
        if (w_in_hs) begin
          out_beat_d = w_in_beat;
        end
      end
    end else if (w_in_hs) begin
      skid_valid_d = 1'b1;
      skid_beat_d  = w_in_beat;
    end
  end

  // Register both entries; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_beat_q   <= '0;
      skid_beat_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_beat_q   <= out_beat_d;
      skid_beat_q  <= skid_beat_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ndata_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : ndata_packetizer
//  Description : Cuts a continuous ndata stream into packets whose element
//                count is taken from a length-word stream, one word per
//                packet, and drives last/keep on each packet's final beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module ndata_packetizer
  import stream_pkg::*;
#(
  parameter bit          ENABLE_SKID_BUFFER = 1'b1,
  parameter int unsigned LENGTH_WIDTH       = LENGTH_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned NUM_ELEMENTS       = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  ready_valid_i.s length,
  ndata_i.s       in,
  ndata_i.m       out
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_STREAM = STREAM;

  logic [0:0]              state_q, state_d;
  logic [LENGTH_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [NUM_ELEMENTS-1:0] tail_keep_q, tail_keep_d;

  logic                    w_streaming;
  logic                    w_counted_last;
  logic                    w_in_hs;
  logic                    w_final_hs;
  logic                    w_len_hs;
  logic [LENGTH_WIDTH-1:0] w_len_beats;
  logic [NUM_ELEMENTS-1:0] w_len_tail_keep;

  ndata_i #(.DATA_WIDTH(DATA_WIDTH), .NUM_ELEMENTS(NUM_ELEMENTS)) internal ();

  // Both readies are held low while reset is asserted, independent of state.
  assign w_streaming    = rst_n && (state_q == ST_STREAM);
  assign w_counted_last = (beats_left_q == LENGTH_WIDTH'(1));

  assign in.ready       = w_streaming && internal.ready;
  assign internal.valid = w_streaming && in.valid;
  assign internal.data  = in.data;
  assign internal.keep  = in.keep & (w_counted_last ? tail_keep_q : '1);
  assign internal.last  = w_counted_last || in.last;

  assign w_in_hs    = in.valid && in.ready;
  assign w_final_hs = w_in_hs && (w_counted_last || in.last);

  // A new length word can be taken on the final beat itself, which keeps the
  // stream at one beat per cycle across packet boundaries.
  assign length.ready = rst_n && ((state_q == ST_IDLE) || w_final_hs);
  assign w_len_hs     = length.valid && length.ready;

  assign w_len_beats     = LENGTH_WIDTH'(decode_beats(DECODE_WIDTH'(length.data), NUM_ELEMENTS));
  assign w_len_tail_keep = NUM_ELEMENTS'(decode_tail_keep(DECODE_WIDTH'(length.data), NUM_ELEMENTS));

  // Packet bookkeeping: count beats down, close on count or early last, and
  // let a length word accepted this cycle override the close.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    tail_keep_d  = tail_keep_q;
    if (w_in_hs) begin
      beats_left_d = beats_left_q - LENGTH_WIDTH'(1);
    end
    if (w_final_hs) begin
      state_d      = ST_IDLE;
      beats_left_d = '0;
    end
    if (w_len_hs) begin
      beats_left_d = w_len_beats;
      tail_keep_d  = w_len_tail_keep;
      state_d      = (length.data != '0) ? ST_STREAM : ST_IDLE;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      tail_keep_q  <= '1;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      tail_keep_q  <= tail_keep_d;
    end
  end

  generate
    if (ENABLE_SKID_BUFFER) begin : g_skid
      NDataSkidBuffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_ELEMENTS(NUM_ELEMENTS)
      ) u_skid (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (internal),
        .out  (out)
      );
    end else begin : g_bypass
      assign out.valid      = internal.valid;
      assign out.data       = internal.data;
      assign out.keep       = internal.keep;
      assign out.last       = internal.last;
      assign internal.ready = out.ready;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ndata_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ndata_packetizer
//  Description : Self-checking bench for ndata_packetizer. Expected output
//                beats are derived from the length list and the input beat
//                list by plain packet arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ndata_packetizer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 16;

  typedef struct packed {
    logic [N-1:0][DW-1:0] data;
    logic [N-1:0]         keep;
    logic                 last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ndata_i #(.DATA_WIDTH(DW), .NUM_ELEMENTS(N)) in_if ();
  ndata_i #(.DATA_WIDTH(DW), .NUM_ELEMENTS(N)) out_if ();
  ready_valid_i #(.WIDTH(LW)) len_if ();

  ndata_packetizer #(
    .ENABLE_SKID_BUFFER(1'b1),
    .LENGTH_WIDTH      (LW),
    .DATA_WIDTH        (DW),
    .NUM_ELEMENTS      (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .length(len_if),
    .in    (in_if),
    .out   (out_if)
  );

  int vectors = 0;
  int errors  = 0;

  int          len_q[$];
  beat_t       in_q[$];
  beat_t       exp_q[$];
  int          exp_in_used;
  int unsigned pct_len, pct_in, pct_out;
  bit          check_contig;

  bit    done;
  int    len_used, in_used, mon_idx, mon_cycles, last_cycle, extra;
  bit    prev_stall;
  beat_t prev_beat, cur;

  function automatic beat_t rnd_beat(input bit last, input bit rnd_keep);
    beat_t b;
    b.data = $urandom;
    b.keep = rnd_keep ? N'($urandom) : '1;
    b.last = last;
    return b;
  endfunction

  function automatic beat_t masked(input beat_t b);
    beat_t r = b;
    for (int i = 0; i < N; i++) if (!b.keep[i]) r.data[i] = '0;
    return r;
  endfunction

  // Reference: each non-zero length L takes ceil(L/N) beats from the input
  // list (fewer if an input beat carries last); the final counted beat keeps
  // only L - j*N lanes.
  function automatic void build_model();
    int k = 0;
    exp_q.delete();
    foreach (len_q[i]) begin
      int L;
      int beats;
      L = len_q[i];
      if (L == 0) continue;
      beats = (L + N - 1) / N;
      for (int j = 0; j < beats && k < in_q.size(); j++) begin
        beat_t b;
        beat_t e;
        int    lanes;
        b = in_q[k];
        k++;
        lanes  = (j == beats - 1) ? L - j * N : N;
        e.data = b.data;
        e.keep = b.keep & N'((1 << lanes) - 1);
        e.last = (j == beats - 1) || b.last;
        exp_q.push_back(e);
        if (b.last) break;
      end
    end
    exp_in_used = k;
  endfunction

  task automatic run_scenario(input string name, input int budget);
    build_model();
    done = 0; mon_idx = 0; mon_cycles = 0; last_cycle = -1; extra = 0; prev_stall = 0;
    fork
      begin
        bit pend;
        int li;
        pend = 0; li = 0;
        while (!done) begin
          @(negedge clk);
          if (done) break;
          if (!pend && li < len_q.size() && $urandom_range(99) < pct_len) pend = 1;
          len_if.valid = pend;
          if (pend) len_if.data = LW'(len_q[li]);
          #1;
          if (pend && len_if.ready === 1'b1) begin pend = 0; li++; end
        end
        len_if.valid = 1'b0;
        len_used = li;
      end
      begin
        bit pend;
        int ii;
        pend = 0; ii = 0;
        while (!done) begin
          @(negedge clk);
          if (done) break;
          if (!pend && ii < in_q.size() && $urandom_range(99) < pct_in) pend = 1;
          in_if.valid = pend;
          if (pend) begin
            in_if.data = in_q[ii].data; in_if.keep = in_q[ii].keep; in_if.last = in_q[ii].last;
          end
          #1;
          if (pend && in_if.ready === 1'b1) begin pend = 0; ii++; end
        end
        in_if.valid = 1'b0;
        in_used = ii;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (done) break;
          out_if.ready = ($urandom_range(99) < pct_out);
        end
        out_if.ready = 1'b1;
      end
      begin
        while (mon_idx < exp_q.size() && mon_cycles < budget) begin
          @(negedge clk); #1;
          mon_cycles++;
          cur = {out_if.data, out_if.keep, out_if.last};
          if (prev_stall) begin
            vectors++;
            if (out_if.valid !== 1'b1 || cur !== prev_beat) begin
              errors++;
              $display("FAIL %s hold: valid=%b beat=%h, required valid=1 beat=%h", name, out_if.valid, cur, prev_beat);
            end
          end
          prev_stall = (out_if.valid === 1'b1) && (out_if.ready !== 1'b1);
          prev_beat  = cur;
          if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
            vectors++;
            if (masked(cur) !== masked(exp_q[mon_idx])) begin
              errors++;
              $display("FAIL %s beat %0d: got %h, required %h", name, mon_idx, masked(cur), masked(exp_q[mon_idx]));
            end
            if (check_contig && last_cycle >= 0) begin
              vectors++;
              if (mon_cycles != last_cycle + 1) begin
                errors++;
                $display("FAIL %s gap before beat %0d: %0d cycles, required 1", name, mon_idx, mon_cycles - last_cycle);
              end
            end
            last_cycle = mon_cycles;
            mon_idx++;
          end
        end
        vectors++;
        if (mon_idx != exp_q.size()) begin
          errors++;
          $display("FAIL %s timeout: %0d beats seen, required %0d", name, mon_idx, exp_q.size());
        end
        for (int i = 0; i < 8; i++) begin
          @(negedge clk); #1;
          if (out_if.valid === 1'b1) extra++;
        end
        done = 1;
      end
    join
    vectors++;
    if (extra != 0) begin
      errors++;
      $display("FAIL %s extra output: %0d valid cycles, required 0", name, extra);
    end
    vectors++;
    if (in_used != exp_in_used) begin
      errors++;
      $display("FAIL %s input consumed: %0d beats, required %0d", name, in_used, exp_in_used);
    end
    vectors++;
    if (len_used != len_q.size()) begin
      errors++;
      $display("FAIL %s length words consumed: %0d, required %0d", name, len_used, len_q.size());
    end
  endtask

  task automatic setup(input int unsigned pl, input int unsigned pi, input int unsigned po, input bit contig);
    len_q.delete(); in_q.delete();
    pct_len = pl; pct_in = pi; pct_out = po; check_contig = contig;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset out.valid: got %b, required 0", out_if.valid); end
    vectors++; if (len_if.ready !== 1'b0) begin errors++; $display("FAIL reset length.ready: got %b, required 0", len_if.ready); end
    vectors++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL reset in.ready: got %b, required 0", in_if.ready); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++; if (len_if.ready !== 1'b1) begin errors++; $display("FAIL idle length.ready: got %b, required 1", len_if.ready); end
    vectors++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL idle in.ready: got %b, required 0", in_if.ready); end
  endtask

  task automatic test_full_packet();
    setup(100, 100, 100, 1'b0);
    len_q.push_back(8);
    repeat (3) in_q.push_back(rnd_beat(1'b0, 1'b0));
    run_scenario("full_packet", 200);
  endtask

  task automatic test_partial_tail();
    setup(100, 100, 100, 1'b0);
    len_q.push_back(6);
    repeat (3) in_q.push_back(rnd_beat(1'b0, 1'b0));
    run_scenario("partial_tail", 200);
  endtask

  task automatic test_zero_length();
    setup(100, 100, 100, 1'b0);
    len_q.push_back(0); len_q.push_back(4); len_q.push_back(0); len_q.push_back(4);
    repeat (3) in_q.push_back(rnd_beat(1'b0, 1'b0));
    run_scenario("zero_length", 200);
  endtask

  task automatic test_back_to_back();
    setup(100, 100, 100, 1'b1);
    len_q.push_back(4); len_q.push_back(8); len_q.push_back(4);
    repeat (5) in_q.push_back(rnd_beat(1'b0, 1'b0));
    run_scenario("back_to_back", 200);
  endtask

  task automatic test_early_last();
    setup(100, 100, 100, 1'b1);
    len_q.push_back(16); len_q.push_back(4);
    in_q.push_back(rnd_beat(1'b0, 1'b0));
    in_q.push_back(rnd_beat(1'b1, 1'b0));
    in_q.push_back(rnd_beat(1'b0, 1'b0));
    in_q.push_back(rnd_beat(1'b0, 1'b0));
    run_scenario("early_last", 200);
  endtask

  task automatic test_random(input string name, input int npkts, input int unsigned pct_last, input bit rnd_keep, input int budget);
    int total;
    total = 0;
    setup(80, 75, 50, 1'b0);
    for (int p = 0; p < npkts; p++) begin
      int L;
      L = int'($urandom_range(64, 1));
      len_q.push_back(L);
      total += (L + N - 1) / N;
    end
    for (int b = 0; b < total + 1; b++) in_q.push_back(rnd_beat($urandom_range(99) < pct_last, rnd_keep));
    run_scenario(name, budget);
  endtask

  task automatic test_reset_mid_packet();
    int hs;
    int c;
    hs = 0; c = 0;
    out_if.ready = 1'b1;
    @(negedge clk);
    len_if.valid = 1'b1; len_if.data = LW'(20);
    #1;
    vectors++; if (len_if.ready !== 1'b1) begin errors++; $display("FAIL midreset length accept: got %b, required 1", len_if.ready); end
    @(negedge clk);
    len_if.valid = 1'b0;
    in_if.valid  = 1'b1;
    while (hs < 3 && c < 20) begin
      in_if.data = $urandom; in_if.keep = '1; in_if.last = 1'b0;
      #1;
      if (in_if.ready === 1'b1) hs++;
      c++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    in_if.valid = 1'b0;
    #1;
    vectors++; if (hs != 3) begin errors++; $display("FAIL midreset beats before reset: got %0d, required 3", hs); end
    vectors++; if (len_if.ready !== 1'b0) begin errors++; $display("FAIL midreset length.ready low: got %b, required 0", len_if.ready); end
    vectors++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL midreset in.ready low: got %b, required 0", in_if.ready); end
    @(negedge clk); #1;
    vectors++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL midreset out.valid: got %b, required 0", out_if.valid); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++; if (len_if.ready !== 1'b1) begin errors++; $display("FAIL midreset idle length.ready: got %b, required 1", len_if.ready); end
    vectors++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL midreset idle in.ready: got %b, required 0", in_if.ready); end
    setup(100, 100, 100, 1'b0);
    len_q.push_back(12);
    repeat (4) in_q.push_back(rnd_beat(1'b0, 1'b0));
    run_scenario("after_reset", 200);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_if.valid = 1'b0; in_if.data = '0; in_if.keep = '0; in_if.last = 1'b0;
    len_if.valid = 1'b0; len_if.data = '0;
    out_if.ready = 1'b0;
    test_reset();
    test_full_packet();
    test_partial_tail();
    test_zero_length();
    test_back_to_back();
    test_early_last();
    test_random("random", 1000, 0, 1'b0, 60000);
    test_random("random_last_keep", 200, 10, 1'b1, 20000);
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
